// File: rtl/hslink_fixed_pkg.sv
// Shared fixed-point helpers: binary-point alignment, signed clamp and range limits.
// All math is carried in a wide signed container and narrowed by the caller.
package hslink_fixed_pkg;

  localparam int unsigned FX_W = 64;

  typedef logic signed [FX_W-1:0] fx_t;

  function automatic fx_t fx_max(input int unsigned bits);
    return (fx_t'(1) <<< (bits - 1)) - fx_t'(1);
  endfunction

  function automatic fx_t fx_min(input int unsigned bits);
    return -(fx_t'(1) <<< (bits - 1));
  endfunction

  // Positive sh drops fractional bits (floor), negative sh adds them.
  function automatic fx_t fx_align(input fx_t x, input int sh);
    if (sh >= 0) return x >>> sh;
    return x <<< (-sh);
  endfunction

  function automatic fx_t fx_sat(input fx_t x, input int unsigned bits, output logic clamped);
    clamped = 1'b0;
    if (x > fx_max(bits)) begin
      clamped = 1'b1;
      return fx_max(bits);
    end
    if (x < fx_min(bits)) begin
      clamped = 1'b1;
      return fx_min(bits);
    end
    return x;
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Term stream in, saturated sum stream out, plus clear and sticky saturation status.
interface prod_accum_if #(
  parameter int unsigned IN_BITS  = 16,
  parameter int unsigned OUT_BITS = 16
);
  logic                       clear;
  logic signed [IN_BITS-1:0]  in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [OUT_BITS-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       sat_flag;

  modport master (
    output clear, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sat_flag
  );

  modport slave (
    input  clear, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sat_flag
  );
endinterface

// File: rtl/fixed_align_sat.sv
// Combinational re-alignment of a signed fixed-point value to a new binary point,
// followed by a clamp to the output width.
module fixed_align_sat
  import hslink_fixed_pkg::*;
#(
  parameter int unsigned IN_BITS   = 24,
  parameter int unsigned IN_POINT  = 12,
  parameter int unsigned OUT_BITS  = 16,
  parameter int unsigned OUT_POINT = 12
) (
  input  logic signed [IN_BITS-1:0]  x,
  output logic signed [OUT_BITS-1:0] y,
  output logic                       clamped
);

  fx_t aligned;

  always_comb begin
    aligned = fx_align(fx_t'(x), int'(IN_POINT) - int'(OUT_POINT));
    y       = OUT_BITS'(fx_sat(aligned, OUT_BITS, clamped));
  end

endmodule

// File: rtl/prod_accum.sv
// Sums N_TERMS consecutive signed products into one saturated output sample,
// with valid/ready on both sides and a sticky saturation flag.
module prod_accum
  import hslink_fixed_pkg::*;
#(
  parameter int unsigned IN_BITS   = 16,
  parameter int unsigned IN_POINT  = 14,
  parameter int unsigned OUT_BITS  = 16,
  parameter int unsigned OUT_POINT = 12,
  parameter int unsigned ACC_BITS  = 24,
  parameter int unsigned N_TERMS   = 8
) (
  input logic         clk,
  input logic         rst_n,
  prod_accum_if.slave bus
);

  localparam int unsigned CNT_BITS = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int          SH       = int'(IN_POINT) - int'(OUT_POINT);

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] term;
  logic signed [ACC_BITS-1:0] sum;
  logic        [CNT_BITS-1:0] cnt;
  logic signed [OUT_BITS-1:0] out_data_q;
  logic signed [OUT_BITS-1:0] sum_sat;
  logic                       sum_clamped;
  logic                       out_valid_q;
  logic                       sat_flag_q;
  logic                       accept;
  logic                       last;

  // Input is back-pressured only while a finished sum waits for the consumer.
  assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_flag_q;

  always_comb begin
    term   = ACC_BITS'(fx_align(fx_t'(bus.in_data), SH));
    sum    = acc + term;
    accept = bus.in_valid && bus.in_ready && !bus.clear;
    last   = (cnt == CNT_BITS'(N_TERMS - 1));
  end

  fixed_align_sat #(
    .IN_BITS  (ACC_BITS),
    .IN_POINT (OUT_POINT),
    .OUT_BITS (OUT_BITS),
    .OUT_POINT(OUT_POINT)
  ) u_sat (
    .x      (sum),
    .y      (sum_sat),
    .clamped(sum_clamped)
  );

  // Accumulator and term counter; clear overrides a same-cycle term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.clear || (accept && last)) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_BITS'(1);
    end
  end

  // Output register: a completing sum reloads even while the previous one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else if (accept && last) begin
      out_data_q  <= sum_sat;
      out_valid_q <= 1'b1;
      if (sum_clamped) sat_flag_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a reference model pushes expected sums on accepted
// terms, a monitor collects output handshakes, and each scenario task compares inline.
module tb_prod_accum;

  localparam int N_TERMS   = 8;
  localparam int SHIFT     = 14 - 12;
  localparam int OUT_MAX   = 32767;
  localparam int OUT_MIN   = -32768;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  prod_accum_if #(.IN_BITS(16), .OUT_BITS(16)) bus ();

  prod_accum dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  res_t got_q[$];
  int   passed = 0;
  int   total  = 0;
  int   m_sum  = 0;
  int   m_cnt  = 0;
  bit   m_sat  = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_data, bus.sat_flag});
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input bit with_sat);
    m_sum = 0;
    m_cnt = 0;
    if (with_sat) m_sat = 1'b0;
  endtask

  // Drives one term from a posedge+1 slot; returns at posedge+1 of the accepting edge.
  task automatic send_term(input logic signed [15:0] d);
    int   n = 0;
    int   v;
    bit   took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!took && n < 200) begin
      @(negedge clk);
      took = bus.in_ready && !bus.clear;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!took) begin
      total++;
      $display("FAIL send_term: term %h never accepted within 200 cycles", d);
    end else begin
      m_sum += (int'(d) >>> SHIFT);
      m_cnt++;
      if (m_cnt == N_TERMS) begin
        v = m_sum;
        if (v > OUT_MAX) begin v = OUT_MAX; m_sat = 1'b1; end
        else if (v < OUT_MIN) begin v = OUT_MIN; m_sat = 1'b1; end
        exp_q.push_back({16'(v), m_sat});
        model_reset(1'b0);
      end
    end
  endtask

  task automatic pop_pair(output res_t e, output res_t g, output bit ok);
    int n = 0;
    while (got_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (got_q.size() != 0) && (exp_q.size() != 0);
    e  = '0;
    g  = '0;
    if (got_q.size() != 0) g = got_q.pop_front();
    if (exp_q.size() != 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL reset out_data: got %h want 0000", bus.out_data); else passed++;
    total++; if (bus.sat_flag !== 1'b0) $display("FAIL reset sat_flag: got %b want 0", bus.sat_flag); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else passed++;
    sync();
    rst_n = 1'b1;
    model_reset(1'b1);
  endtask

  task automatic test_half();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < N_TERMS - 1; i++) send_term(16'sh2000);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL half early out_valid: got %b want 0", bus.out_valid); else passed++;
    send_term(16'sh2000);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL half latency out_valid: got %b want 1", bus.out_valid); else passed++;
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h4000) $display("FAIL half sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_neg();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < N_TERMS; i++) send_term(16'shC000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h8000) $display("FAIL neg sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_saturate();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < N_TERMS; i++) send_term(16'sh4000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e !== {16'h7FFF, 1'b1}) $display("FAIL saturate sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_stall();
    res_t e, g;
    bit   ok;
    sync();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_TERMS; i++) send_term(16'sh2000);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh2000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) $display("FAIL stall in_ready cyc%0d: got %b want 0", i, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4000) $display("FAIL stall hold cyc%0d: got %b/%h want 1/4000", i, bus.out_valid, bus.out_data); else passed++;
    end
    sync();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e) $display("FAIL stall released sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
    sync();
    for (int i = 0; i < N_TERMS; i++) send_term(16'sh1000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h2000) $display("FAIL stall resume sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_clear();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < 3; i++) send_term(16'sh2000);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh4000;
    sync();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    model_reset(1'b0);
    for (int i = 0; i < N_TERMS; i++) send_term(16'sh1000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h2000) $display("FAIL clear sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_midreset();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < 5; i++) send_term(16'sh2000);
    rst_n = 1'b0;
    #2;
    total++; if (bus.sat_flag !== 1'b0) $display("FAIL midreset sat_flag: got %b want 0", bus.sat_flag); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL midreset out_valid: got %b want 0", bus.out_valid); else passed++;
    sync();
    rst_n = 1'b1;
    model_reset(1'b1);
    for (int i = 0; i < N_TERMS; i++) send_term(16'sh2000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e !== {16'h4000, 1'b0}) $display("FAIL midreset sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_alternate();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < N_TERMS; i++) send_term((i % 2 == 0) ? 16'sh2000 : 16'shE000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h0000) $display("FAIL alternate sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    bit   ok;
    sync();
    for (int i = 0; i < 2 * N_TERMS; i++) send_term((i < N_TERMS) ? 16'sh1000 : 16'shF000);
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'h2000) $display("FAIL b2b first sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
    pop_pair(e, g, ok);
    total++; if (!ok || g !== e || e.data !== 16'hE000) $display("FAIL b2b second sum: got %h/%b want %h/%b", g.data, g.sat, e.data, e.sat); else passed++;
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() != 0 || got_q.size() != 0) $display("FAIL scoreboard drain: got exp=%0d got=%0d want 0/0", exp_q.size(), got_q.size()); else passed++;
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_half();
    test_neg();
    test_saturate();
    test_stall();
    test_clear();
    test_midreset();
    test_alternate();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
